// File: rtl/game_state_ctrl.sv
// Tank-game screen sequencer: menu, play, continue and final screens, with level, tank and lives counters.
// Latency: one cycle from an input pulse to the state/counter update. Backpressure: none; pulses are consumed as they arrive.
module game_state_ctrl #(
  parameter int NUM_LEVELS      = 3,
  parameter int TANKS_PER_LEVEL = 20,
  parameter int PLAYER_LIVES    = 3,
  parameter int CONTINUE_FRAMES = 120
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       frame_tick_i,
  input  logic       enemy_killed_i,
  input  logic       player_hit_i,
  output logic       is_menu_o,
  output logic       is_playing_o,
  output logic       is_continue_o,
  output logic       is_final_o,
  output logic [2:0] level_o,
  output logic [4:0] tanks_left_o,
  output logic [1:0] lives_o,
  output logic       level_start_o,
  output logic       game_won_o
);

  localparam int FW = $clog2(CONTINUE_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_MENU     = 2'd0,
    ST_PLAYING  = 2'd1,
    ST_CONTINUE = 2'd2,
    ST_FINAL    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      level_q, level_d;
  logic [4:0]      tanks_q, tanks_d, tanks_dec;
  logic [1:0]      lives_q, lives_d, lives_dec;
  logic [FW-1:0]   frame_q, frame_d, frame_inc;
  logic            won_q, won_d;
  logic            start_prev_q;
  logic            level_start_q;
  logic            start_press;

  // start_prev resets high so a button held through reset is not a press.
  assign start_press = start_i & ~start_prev_q;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    tanks_d   = tanks_q;
    lives_d   = lives_q;
    won_d     = won_q;
    frame_d   = frame_q;
    tanks_dec = (enemy_killed_i && tanks_q != 5'd0) ? tanks_q - 5'd1 : tanks_q;
    lives_dec = (player_hit_i && lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
    frame_inc = frame_q + FW'(1);

    unique case (state_q)
      ST_MENU: begin
        if (start_press) begin
          state_d = ST_PLAYING;
          level_d = 3'd1;
          tanks_d = 5'(TANKS_PER_LEVEL);
          lives_d = 2'(PLAYER_LIVES);
        end
      end
      ST_PLAYING: begin
        tanks_d = tanks_dec;
        lives_d = lives_dec;
        // Losing the last life wins over clearing the last tank in the same cycle.
        if (player_hit_i && lives_q == 2'd1) begin
          state_d = ST_FINAL;
          won_d   = 1'b0;
        end else if (enemy_killed_i && tanks_q == 5'd1) begin
          if (level_q == 3'(NUM_LEVELS)) begin
            state_d = ST_FINAL;
            won_d   = 1'b1;
          end else begin
            state_d = ST_CONTINUE;
            frame_d = '0;
          end
        end
      end
      ST_CONTINUE: begin
        if (frame_tick_i) begin
          frame_d = frame_inc;
          if (frame_inc == FW'(CONTINUE_FRAMES)) begin
            state_d = ST_PLAYING;
            level_d = level_q + 3'd1;
            tanks_d = 5'(TANKS_PER_LEVEL);
          end
        end
      end
      ST_FINAL: begin
        if (start_press) begin
          state_d = ST_MENU;
          won_d   = 1'b0;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_MENU;
      level_q       <= 3'd1;
      tanks_q       <= 5'd0;
      lives_q       <= 2'd0;
      won_q         <= 1'b0;
      frame_q       <= '0;
      start_prev_q  <= 1'b1;
      level_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      tanks_q       <= tanks_d;
      lives_q       <= lives_d;
      won_q         <= won_d;
      frame_q       <= frame_d;
      start_prev_q  <= start_i;
      level_start_q <= (state_d == ST_PLAYING) && (state_q != ST_PLAYING);
    end
  end

  assign is_menu_o     = (state_q == ST_MENU);
  assign is_playing_o  = (state_q == ST_PLAYING);
  assign is_continue_o = (state_q == ST_CONTINUE);
  assign is_final_o    = (state_q == ST_FINAL);
  assign level_o       = level_q;
  assign tanks_left_o  = tanks_q;
  assign lives_o       = lives_q;
  assign level_start_o = level_start_q;
  assign game_won_o    = won_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEVELS, default 3, giving the number of levels per game.
REQ-002 The block SHALL have parameter TANKS_PER_LEVEL, default 20, giving the enemy tanks loaded at each level start.
REQ-003 The block SHALL have parameter PLAYER_LIVES, default 3, giving the lives loaded at game start.
REQ-004 The block SHALL have parameter CONTINUE_FRAMES, default 120, giving the frame ticks spent on the continue screen.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port start_i, input, 1 bit: start/confirm button level, already synchronised.
REQ-008 The block SHALL have port frame_tick_i, input, 1 bit: one-cycle pulse per video frame.
REQ-009 The block SHALL have port enemy_killed_i, input, 1 bit: one-cycle pulse per enemy tank destroyed.
REQ-010 The block SHALL have port player_hit_i, input, 1 bit: one-cycle pulse per hit on the player tank.
REQ-011 The block SHALL have ports is_menu_o, is_playing_o, is_continue_o and is_final_o, output, 1 bit each: one-hot screen selects for the RGB renderer.
REQ-012 The block SHALL have port level_o, output, 3 bits: current level, 1..NUM_LEVELS.
REQ-013 The block SHALL have port tanks_left_o, output, 5 bits: enemy tanks remaining in the level.
REQ-014 The block SHALL have port lives_o, output, 2 bits: player lives remaining.
REQ-015 The block SHALL have port level_start_o, output, 1 bit: one-cycle pulse on entry to PLAYING.
REQ-016 The block SHALL have port game_won_o, output, 1 bit: result flag, valid in FINAL.

Function
REQ-017 The block SHALL implement FSM states MENU, PLAYING, CONTINUE and FINAL, with exactly one is_*_o output high, decoded from the registered state.
REQ-018 The block SHALL detect a start press as a rising edge of start_i, using a previous-value register whose reset value is 1 so that a button held through reset does not count as a press.
REQ-019 In MENU, on a start press the block SHALL go to PLAYING and load level=1, tanks_left=TANKS_PER_LEVEL and lives=PLAYER_LIVES.
REQ-020 In PLAYING, each enemy_killed_i pulse SHALL decrement tanks_left, saturating at 0.
REQ-021 In PLAYING, each player_hit_i pulse SHALL decrement lives, saturating at 0.
REQ-022 In PLAYING, when a decrement makes lives 0, the block SHALL go to FINAL with game_won=0.
REQ-023 In PLAYING, when a decrement makes tanks_left 0 and lives stays non-zero: if level==NUM_LEVELS the block SHALL go to FINAL with game_won=1; otherwise it SHALL go to CONTINUE and clear the frame counter.
REQ-024 When enemy_killed_i and player_hit_i are both asserted in the same cycle, both counters SHALL update and the loss condition SHALL take priority over the level-clear condition.
REQ-025 In CONTINUE, the block SHALL count frame_tick_i pulses; on the tick that brings the count to CONTINUE_FRAMES it SHALL go to PLAYING, increment level, reload tanks_left and retain lives.
REQ-026 Outside PLAYING, enemy_killed_i and player_hit_i SHALL be ignored.
REQ-027 In FINAL, the block SHALL hold level_o, tanks_left_o, lives_o and game_won_o; on a start press it SHALL go to MENU and clear game_won.
REQ-028 All transitions and counter updates SHALL take effect on the clock edge after the triggering input cycle (1-cycle latency).
REQ-029 level_start_o SHALL be high for exactly the first cycle in which is_playing_o is high after each entry to PLAYING.
REQ-030 Start presses in PLAYING and CONTINUE SHALL be ignored.

Reset
REQ-031 While rst_ni is low, the block SHALL force: state=MENU (is_menu_o=1, the other selects 0), level_o=1, tanks_left_o=0, lives_o=0, level_start_o=0, game_won_o=0, frame counter=0, start_prev=1.
REQ-032 Reset asserted in any state mid-game SHALL abort the game immediately, with no pulse generated on release.

Verification
REQ-033 Reset with start_i=1, then release while still held -> stays MENU; release and press start -> is_playing_o=1 one cycle after the edge, level_o=1, tanks_left_o=20, lives_o=3, level_start_o pulses once.
REQ-034 In PLAYING at level 1, 20 enemy_killed_i pulses -> tanks_left_o counts down to 0, then CONTINUE; 120 frame_tick_i pulses -> PLAYING, level_o=2, tanks_left_o=20, lives unchanged, level_start_o pulse.
REQ-035 At level 3, kill the last tank -> FINAL with game_won_o=1; start press -> MENU with game_won_o=0.
REQ-036 With lives_o=1 and tanks_left_o=1, assert enemy_killed_i and player_hit_i in the same cycle -> FINAL, game_won_o=0, tanks_left_o=0, lives_o=0.
REQ-037 In CONTINUE and in MENU, pulse enemy_killed_i, player_hit_i and start_i -> counters unchanged and no transition from the kill/hit pulses; in MENU, only the start edge causes a transition.
REQ-038 Assert rst_ni low mid-PLAYING, asynchronously between clock edges -> outputs take their REQ-031 values without waiting for a clock edge.
